// File: rtl/wb_trace_recorder.sv
// Writeback trace recorder: FWFT FIFO of (pc, waddr, wdata), 1-cycle capture-to-valid, drops and flags on full unless popped the same cycle.
// Optional WB_TRACE_DROP_CNT_EN adds a saturating 16-bit dropped-record counter port trace_drop_cnt.
module wb_trace_recorder #(
    parameter int          FIFO_DEPTH = 16,
    parameter int          ADDR_W     = 4,
    parameter logic [31:0] END_ADDR   = 32'd12
) (
    input  logic        mips_cpu_clk,
    input  logic        mips_cpu_reset,
    input  logic        rf_wen,
    input  logic [4:0]  rf_waddr,
    input  logic [31:0] rf_wdata,
    input  logic [31:0] wb_pc,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [4:0]  trace_wnum,
    output logic [31:0] trace_wdata,
    output logic        trace_overflow,
`ifdef WB_TRACE_DROP_CNT_EN
    output logic [15:0] trace_drop_cnt,
`endif
    output logic        trace_done
);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } rec_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(FIFO_DEPTH);

    state_t            state, state_nxt;
    rec_t              mem [FIFO_DEPTH];
    rec_t              rec_in;
    rec_t              head;
    logic [ADDR_W-1:0] rd_ptr, wr_ptr, rd_next;
    logic [ADDR_W:0]   count, after_pop;
    logic              full, capture, end_evt, pop, push, drop;

    assign rec_in    = '{pc: wb_pc, wnum: rf_waddr, wdata: rf_wdata};
    assign full      = (count == DEPTH_C);
    assign capture   = (state == RUN) && rf_wen && (rf_waddr != 5'd0);
    assign end_evt   = (state == RUN) && mem_write && (mem_wdata == 32'd0) && (mem_address == END_ADDR);
    assign pop       = trace_valid && trace_ready;
    assign push      = capture && (!full || pop);
    assign drop      = capture && full && !pop;
    assign after_pop = count - (ADDR_W + 1)'(pop);
    assign rd_next   = rd_ptr + ADDR_W'(pop);

    assign trace_valid = (count != '0);
    assign trace_pc    = head.pc;
    assign trace_wnum  = head.wnum;
    assign trace_wdata = head.wdata;
    assign trace_done  = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (end_evt) state_nxt = DRAIN;
            DRAIN:   if (count == '0) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge mips_cpu_clk) begin
        if (push) mem[wr_ptr] <= rec_in;
    end

    // The output register always holds the entry that will be head after this edge:
    // the next stored entry if one survives the pop, otherwise the record being pushed.
    always_ff @(posedge mips_cpu_clk) begin
        if (mips_cpu_reset) begin
            state  <= RUN;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            state <= state_nxt;
            count <= count + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(pop);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_next;
            if (after_pop != '0)
                head <= mem[rd_next];
            else if (push)
                head <= rec_in;
        end
    end

`ifdef WB_TRACE_DROP_CNT_EN
    always_ff @(posedge mips_cpu_clk) begin
        if (mips_cpu_reset)
            trace_drop_cnt <= '0;
        else if (drop && (trace_drop_cnt != 16'hFFFF))
            trace_drop_cnt <= trace_drop_cnt + 16'd1;
    end

    assign trace_overflow = (trace_drop_cnt != 16'd0);
`else
    always_ff @(posedge mips_cpu_clk) begin
        if (mips_cpu_reset)
            trace_overflow <= 1'b0;
        else if (drop)
            trace_overflow <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_wb_trace_recorder.sv
// Bench for wb_trace_recorder: directed scenarios plus randomized traffic, checked against a queue-based model every cycle.
module tb_wb_trace_recorder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, wb_pc;
    logic        mem_write;
    logic [31:0] mem_address, mem_wdata;
    logic        trace_valid, trace_ready;
    logic [31:0] trace_pc, trace_wdata;
    logic [4:0]  trace_wnum;
    logic        trace_overflow, trace_done;
`ifdef WB_TRACE_DROP_CNT_EN
    logic [15:0] trace_drop_cnt;
`endif

    wb_trace_recorder dut (
        .mips_cpu_clk   (clk),
        .mips_cpu_reset (rst),
        .rf_wen         (rf_wen),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .wb_pc          (wb_pc),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_pc       (trace_pc),
        .trace_wnum     (trace_wnum),
        .trace_wdata    (trace_wdata),
        .trace_overflow (trace_overflow),
`ifdef WB_TRACE_DROP_CNT_EN
        .trace_drop_cnt (trace_drop_cnt),
`endif
        .trace_done     (trace_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wn;
        logic [31:0] wd;
    } rec_t;

    rec_t q[$];
    rec_t log_q[$];
    int   phase;
    bit   m_ovf;
    int   m_drops;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic rec_t mk(input logic [31:0] pc, input logic [4:0] wn, input logic [31:0] wd);
        rec_t r;
        r.pc = pc; r.wn = wn; r.wd = wd;
        return r;
    endfunction

    task automatic idle_inputs();
        rf_wen = 0; rf_waddr = 0; rf_wdata = 0; wb_pc = 0;
        mem_write = 0; mem_address = 0; mem_wdata = 0;
    endtask

    // One clock: log DUT pops, advance model from the spec's rules, compare outputs after the edge.
    task automatic cycle();
        bit pop, cap, endv;
        int sz;
        if (trace_valid && trace_ready)
            log_q.push_back(mk(trace_pc, trace_wnum, trace_wdata));
        @(posedge clk);
        if (rst) begin
            q.delete(); phase = 0; m_ovf = 0; m_drops = 0;
        end else begin
            sz   = q.size();
            pop  = (sz != 0) && trace_ready;
            cap  = (phase == 0) && rf_wen && (rf_waddr != 0);
            endv = (phase == 0) && mem_write && (mem_wdata == 0) && (mem_address == 32'd12);
            if (pop) void'(q.pop_front());
            if (cap) begin
                if (sz == 16 && !pop) begin
                    m_ovf = 1;
                    if (m_drops < 65535) m_drops++;
                end else
                    q.push_back(mk(wb_pc, rf_waddr, rf_wdata));
            end
            if (phase == 0 && endv) phase = 1;
            else if (phase == 1 && sz == 0) phase = 2;
        end
        #1;
        check("valid", 72'(trace_valid), 72'(q.size() != 0));
        if (q.size() != 0)
            check("head", 72'(mk(trace_pc, trace_wnum, trace_wdata)), 72'(q[0]));
        check("overflow", 72'(trace_overflow), 72'(m_ovf));
        check("done", 72'(trace_done), 72'(phase == 2));
`ifdef WB_TRACE_DROP_CNT_EN
        check("drop_cnt", 72'(trace_drop_cnt), 72'(m_drops));
`endif
    endtask

    task automatic wr(input logic [31:0] pc, input logic [4:0] wn, input logic [31:0] wd);
        rf_wen = 1; wb_pc = pc; rf_waddr = wn; rf_wdata = wd;
        cycle();
        idle_inputs();
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] wd);
        mem_write = 1; mem_address = addr; mem_wdata = wd;
        cycle();
        idle_inputs();
    endtask

    task automatic do_reset();
        rst = 1;
        cycle();
        cycle();
        rst = 0;
        log_q.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int rdy_pct;
        rst = 1; trace_ready = 0; idle_inputs();
        phase = 0; m_ovf = 0; m_drops = 0;
        do_reset();
        check("rst_valid", 72'(trace_valid), 72'(0));
        check("rst_fields", 72'(mk(trace_pc, trace_wnum, trace_wdata)), 72'(0));
        check("rst_ovf", 72'(trace_overflow), 72'(0));
        check("rst_done", 72'(trace_done), 72'(0));

        // 1: $0 writes are never recorded
        trace_ready = 1;
        wr(32'h0, 5'd1, 32'h5);
        check("t1_lat_valid", 72'(trace_valid), 72'(1));
        wr(32'h4, 5'd0, 32'h9);
        wr(32'h8, 5'd2, 32'hA);
        idle(3);
        check("t1_count", 72'(log_q.size()), 72'(2));
        if (log_q.size() == 2) begin
            check("t1_rec0", 72'(log_q[0]), 72'(mk(32'h0, 5'd1, 32'h5)));
            check("t1_rec1", 72'(log_q[1]), 72'(mk(32'h8, 5'd2, 32'hA)));
        end

        // 2: overflow on 17th capture while stalled
        do_reset();
        trace_ready = 0;
        for (int i = 1; i <= 17; i++) wr(32'(i * 4), 5'(i), 32'(i));
        check("t2_ovf", 72'(trace_overflow), 72'(1));
        trace_ready = 1;
        idle(20);
        check("t2_count", 72'(log_q.size()), 72'(16));
        for (int i = 0; i < 16 && i < log_q.size(); i++)
            check("t2_order", 72'(log_q[i]), 72'(mk(32'((i + 1) * 4), 5'(i + 1), 32'(i + 1))));
`ifdef WB_TRACE_DROP_CNT_EN
        check("t2_dropcnt", 72'(trace_drop_cnt), 72'(1));
`endif

        // 3: full plus pop plus capture in the same cycle
        do_reset();
        trace_ready = 0;
        for (int i = 1; i <= 16; i++) wr(32'(i * 4), 5'(i), 32'(i));
        trace_ready = 1;
        wr(32'h100, 5'd20, 32'h99);
        check("t3_ovf", 72'(trace_overflow), 72'(0));
        idle(20);
        check("t3_count", 72'(log_q.size()), 72'(17));
        if (log_q.size() == 17)
            check("t3_last", 72'(log_q[16]), 72'(mk(32'h100, 5'd20, 32'h99)));

        // 4: end marker with records pending
        do_reset();
        trace_ready = 0;
        for (int i = 1; i <= 3; i++) wr(32'(i * 4), 5'(i), 32'(i));
        store(32'd12, 32'd0);
        wr(32'h40, 5'd9, 32'h1);
        wr(32'h44, 5'd10, 32'h2);
        trace_ready = 1;
        idle(3);
        check("t4_count", 72'(log_q.size()), 72'(3));
        check("t4_done_lag", 72'(trace_done), 72'(0));
        cycle();
        check("t4_done", 72'(trace_done), 72'(1));
        idle(4);
        check("t4_done_hold", 72'(trace_done), 72'(1));
        check("t4_no_more", 72'(log_q.size()), 72'(3));

        // 5: near-miss end markers, then capture coincident with end marker
        do_reset();
        trace_ready = 1;
        store(32'd12, 32'd1);
        store(32'd16, 32'd0);
        wr(32'h50, 5'd4, 32'h44);
        rf_wen = 1; wb_pc = 32'h54; rf_waddr = 5'd3; rf_wdata = 32'h33;
        mem_write = 1; mem_address = 32'd12; mem_wdata = 32'd0;
        cycle();
        idle_inputs();
        wr(32'h58, 5'd5, 32'h55);
        idle(4);
        check("t5_count", 72'(log_q.size()), 72'(2));
        if (log_q.size() == 2) begin
            check("t5_rec0", 72'(log_q[0]), 72'(mk(32'h50, 5'd4, 32'h44)));
            check("t5_rec1", 72'(log_q[1]), 72'(mk(32'h54, 5'd3, 32'h33)));
        end

        // 6: reset while draining flushes everything
        do_reset();
        trace_ready = 0;
        for (int i = 1; i <= 5; i++) wr(32'(i * 4), 5'(i), 32'(i));
        store(32'd12, 32'd0);
        rst = 1;
        cycle();
        rst = 0;
        check("t6_valid", 72'(trace_valid), 72'(0));
        check("t6_done", 72'(trace_done), 72'(0));
        check("t6_ovf", 72'(trace_overflow), 72'(0));
        wr(32'h80, 5'd7, 32'h77);
        check("t6_resume", 72'(trace_valid), 72'(1));

        // Randomized traffic with bursty consumer, rare end markers and resets
        do_reset();
        rdy_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) rdy_pct = $urandom_range(0, 100);
            trace_ready = ($urandom_range(0, 99) < rdy_pct);
            rf_wen      = ($urandom_range(0, 9) < 7);
            rf_waddr    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            rf_wdata    = $urandom;
            wb_pc       = $urandom;
            mem_write   = ($urandom_range(0, 19) == 0);
            mem_address = ($urandom_range(0, 9) == 0) ? 32'd12 : 32'($urandom_range(0, 4) * 4);
            mem_wdata   = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(0, 3));
            rst         = ($urandom_range(0, 399) == 0);
            cycle();
        end
        rst = 0;
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
